mem_dump_reader: RTL and testbench
==================================

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 10, width of the debug read address driven to the processor wrapper.
REQ-002 Parameter DATA_W, default 16, width of the debug read data returned by the wrapper.
REQ-003 Parameter RD_LAT, default 1, number of cycles from a stable address to valid read data; legal range 1..7.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first address of the dump; captured when start is accepted.
REQ-008 count  input  ADDR_W+1  number of words to dump (0..1024); captured when start is accepted.
REQ-009 select  output  1  debug-port select to the wrapper; 1 switches the wrapper output to memory read.
REQ-010 inp  output  ADDR_W  debug read address to the wrapper.
REQ-011 out  input  DATA_W  debug read data from the wrapper.
REQ-012 dout  output  DATA_W  dumped word toward the consumer.
REQ-013 dout_valid  output  1  dout holds a word; stays asserted until accepted.
REQ-014 dout_ready  input  1  consumer accepts dout when high together with dout_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, VALID, FINISH; the CSUM state exists only under REQ-031.
REQ-018 IDLE: on start=1, latch base_addr into the address register and count into the remaining counter; go to WAIT if count!=0, else go to FINISH.
REQ-019 WAIT: select=1 and inp=the address register; a latency counter runs RD_LAT cycles; on its last cycle, out is registered into dout and the FSM goes to VALID.
REQ-020 Latency: start sampled at cycle 0 gives dout_valid=1 at cycle RD_LAT+1.
REQ-021 VALID: dout_valid=1, and dout, inp and select are held stable until dout_valid and dout_ready are both 1 on a rising edge.
REQ-022 On that handshake: the address increments modulo 2^ADDR_W (1023 wraps to 0) and remaining decrements; go to WAIT if remaining was greater than 1, else go to FINISH.
REQ-023 Throughput with dout_ready held at 1: one word every RD_LAT+1 cycles.
REQ-024 FINISH: done=1 and select=0 for exactly one cycle, then IDLE.
REQ-025 start is ignored while busy=1; the captured base_addr and count are not disturbed by input changes after acceptance.
REQ-026 dout_ready without dout_valid has no effect; dout_valid never depends combinationally on dout_ready.
REQ-027 select=0 in IDLE and FINISH, so the wrapper output reverts to its normal view.

Reset
REQ-028 Asserting rst, including mid-dump, SHALL immediately force IDLE, select=0, inp=0, dout=0, dout_valid=0, busy=0, done=0, and clear the counters (and checksum).
REQ-029 After rst deasserts, the block SHALL accept a start on the first rising edge.

Configuration
REQ-030 Macro DUMP_CHECKSUM_EN selects an end-of-dump checksum word.
REQ-031 With DUMP_CHECKSUM_EN defined:
- A DATA_W-bit modulo-2^DATA_W sum of all accepted words is kept.
- After the last word's handshake the FSM enters CSUM, presenting dout=sum with dout_valid=1 and select=0 until handshake, then goes to FINISH.
- count=0 still emits one checksum word of 0.
REQ-032 Without DUMP_CHECKSUM_EN: no checksum logic or CSUM state; the behaviour is exactly REQ-017..REQ-027.

Verification
REQ-033 Model memory with mem[a]=a*3, RD_LAT=1, dout_ready=1; start with base=5, count=4 -> dout 15,18,21,24 at cycles 2,4,6,8; done pulse at cycle 9; select high during cycles 1..8 only.
REQ-034 base=1022, count=3 -> inp sequence 1022,1023,0; dout 3066,3069,0 (mem[1022]=3066 mod 2^16, mem[1023]=3069, mem[0]=0).
REQ-035 dout_ready held 0 for 5 cycles in the first VALID -> dout, inp and dout_valid are stable throughout; no word is lost or duplicated.
REQ-036 count=0 -> done at cycle 1, no dout_valid, select stays 0 (no macro); with the macro, a single word 0 is emitted, then done.
REQ-037 rst pulsed in the middle of a count=8 dump -> all outputs are 0 immediately; a new start with base=0, count=1 yields dout=0 correctly.
REQ-038 With DUMP_CHECKSUM_EN, base=5, count=4 -> a fifth word 78 (15+18+21+24) with select=0, then done.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Debug memory dump reader: walks an address range through the wrapper's debug
// read port and streams each word out over a valid/ready handshake.
// Optional checksum trailer word is enabled with `define DUMP_CHECKSUM_EN.
module mem_dump_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              select,
  output logic [ADDR_W-1:0] inp,
  input  logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, WAIT, VALID, FINISH, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, VALID, FINISH} state_t;
`endif

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [2:0]        lat;
  logic [DATA_W-1:0] dout_r;
  logic              lat_last, hs, last_word;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign lat_last  = (lat == 3'(RD_LAT - 1));
  assign hs        = dout_valid && dout_ready;
  assign last_word = (remaining <= (ADDR_W+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) begin
        if (count != '0) nxt = WAIT;
`ifdef DUMP_CHECKSUM_EN
        else             nxt = CSUM;
`else
        else             nxt = FINISH;
`endif
      end
      WAIT:   if (lat_last) nxt = VALID;
      VALID:  if (hs) begin
        if (!last_word) nxt = WAIT;
`ifdef DUMP_CHECKSUM_EN
        else            nxt = CSUM;
`else
        else            nxt = FINISH;
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM:   if (hs) nxt = FINISH;
`endif
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Address is only exposed while the wrapper is switched to the memory view.
  assign select     = (state == WAIT) || (state == VALID);
  assign inp        = select ? addr : '0;
  assign dout       = dout_r;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
`ifdef DUMP_CHECKSUM_EN
  assign dout_valid = (state == VALID) || (state == CSUM);
`else
  assign dout_valid = (state == VALID);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      lat       <= '0;
      dout_r    <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= count;
          lat       <= '0;
`ifdef DUMP_CHECKSUM_EN
          sum       <= '0;
          if (count == '0) dout_r <= '0;
`endif
        end
        WAIT: begin
          if (lat_last) begin
            dout_r <= out;
            lat    <= '0;
          end else begin
            lat    <= lat + 3'd1;
          end
        end
        VALID: if (dout_ready) begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
`ifdef DUMP_CHECKSUM_EN
          sum       <= sum + dout_r;
          // The trailer word is loaded directly so CSUM reuses the dout register.
          if (last_word) dout_r <= sum + dout_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: stimulus pushes expected words, a
// negedge monitor pops and compares on every accepted output word.
module tb_mem_dump_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk = 0;
  logic              rst = 1;
  logic              start = 0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              select;
  logic [ADDR_W-1:0] inp;
  logic [DATA_W-1:0] out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 0;
  logic              busy;
  logic              done;

  mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .select(select), .inp(inp), .out(out), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memf(input int a);
    return DATA_W'(a * 3);
  endfunction
  assign out = memf(int'(inp));

  typedef struct {
    int d;
    int a;
    bit cs;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_hold = 0;
  bit rand_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Consumer: ready held low for rdy_hold VALID cycles, else 1 or random.
  initial forever begin
    @(posedge clk); #1;
    if (rdy_hold > 0) begin
      dout_ready = 0;
      if (dout_valid) rdy_hold--;
    end else begin
      dout_ready = rand_mode ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor
  bit stall_prev = 0;
  int p_dout, p_inp;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && dout_valid) begin
        chk("hold_dout", dout, p_dout);
        chk("hold_inp", inp, p_inp);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %0d expected none (cycle %0d)", dout, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(e.cs ? "csum_data" : "word_data", dout, e.d);
          if (e.cs) chk("csum_select", select, 0);
          else begin
            chk("word_inp", inp, e.a);
            chk("word_select", select, 1);
          end
          if (e.cyc >= 0) chk("word_cycle", cyc, e.cyc);
        end
      end
      if (!busy || done) begin
        chk("idle_select", select, 0);
        chk("idle_inp", inp, 0);
      end
      if (!busy) chk("idle_valid", dout_valid, 0);
      stall_prev = dout_valid && !dout_ready;
      p_dout = dout;
      p_inp = inp;
    end
  end

  task automatic push_exp(input int b, input int n, input bit tchk, input int st);
    int sum = 0;
    for (int k = 0; k < n; k++) begin
      int a, d;
      a = (b + k) % (1 << ADDR_W);
      d = int'(memf(a));
      sum = (sum + d) % (1 << DATA_W);
      exp_q.push_back('{d, a, 1'b0, tchk ? st + (RD_LAT + 1) * (k + 1) : -1});
    end
    if (CS == 1)
      exp_q.push_back('{sum, 0, 1'b1, tchk ? st + (RD_LAT + 1) * n + 1 : -1});
  endtask

  // Call just after a rising edge; start is sampled on the next one.
  task automatic dump(input int b, input int n, input bit tchk, input bit junk);
    int st, dcyc;
    bit got;
    start = 1; base_addr = ADDR_W'(b); count = (ADDR_W+1)'(n);
    st = cyc;
    push_exp(b, n, tchk, st);
    @(posedge clk); #1;
    start = 0;
    base_addr = ADDR_W'($urandom);
    count = (ADDR_W+1)'($urandom);
    got = 0; dcyc = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; dcyc = cyc; break; end
      if (junk) start = 1'($urandom % 2);
    end
    start = 0;
    chk("done_seen", got, 1);
    if (tchk && got) chk("done_cycle", dcyc - st, (RD_LAT + 1) * n + 1 + CS);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("rst_select", select, 0);
    chk("rst_inp", inp, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    dump(5, 4, 1, 0);
    dump(1022, 3, 1, 0);
    rdy_hold = 5;
    dump(5, 4, 0, 0);
    dump(0, 0, 1, 0);
    dump(7, 1024, 1, 0);

    // Reset in the middle of a long dump
    start = 1; base_addr = 10'd3; count = 11'd8;
    push_exp(3, 8, 0, 0);
    @(posedge clk); #1 start = 0;
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_select", select, 0);
    chk("mid_rst_inp", inp, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 0;
    dump(0, 1, 1, 0);

    rand_mode = 1;
    for (int t = 0; t < 20; t++)
      dump(int'($urandom_range(0, 1023)), int'($urandom_range(0, 12)), 0, 1);
    rand_mode = 0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
